// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ready handshake, holds the
// word for decode until it retires, resolves the next PC, and halts on a sticky fault.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        nebranch,
  input  logic        jmp,
  input  logic        jal,
  input  logic        jr,
  input  logic        alu_zero,
  input  logic [31:0] jr_target,
  output logic [31:0] link_addr,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   ipc_q, ipc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fc_q, fc_d;

  logic [31:0]   pc4, btgt, jtgt, next_pc;
  logic          take;
  logic          unused_jal;

  // jal only matters to the register file; the target comes from the jmp path
  assign unused_jal = jal;

  assign pc4     = ipc_q + 32'd4;
  assign btgt    = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jtgt    = {pc4[31:28], instr_q[25:0], 2'b00};
  assign take    = (branch & alu_zero) | (nebranch & ~alu_zero);
  assign next_pc = jr   ? jr_target :
                   jmp  ? jtgt      :
                   take ? btgt      : pc4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          fc_d    = 2'b01;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          // a misaligned jr target halts with the PC left at the faulting jr
          if (jr && (jr_target[1:0] != 2'b00)) begin
            fc_d    = 2'b10;
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      ipc_q   <= RESET_PC;
      cnt_q   <= '0;
      fc_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
    end
  end

  // gate with rst_n so no request is visible while reset is held
  assign imem_req    = rst_n && (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign link_addr   = pc4;
  assign fault       = (state_q == S_HALT);
  assign fault_code  = fc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: sequential fetch, branches, jumps, jr, wrap,
// timeout and reset behaviour against hand-computed values.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch, nebranch, jmp, jal, jr, alu_zero;
  logic [31:0] jr_target;
  logic [31:0] link_addr;
  logic        fault;
  logic [1:0]  fault_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch(branch), .nebranch(nebranch), .jmp(jmp), .jal(jal), .jr(jr),
    .alu_zero(alu_zero), .jr_target(jr_target),
    .link_addr(link_addr), .fault(fault), .fault_code(fault_code)
  );

  // Called at a negedge in FETCH; leaves the DUT in HOLD at the next negedge.
  task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_addr, input string tag);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_fetch req=%0b addr=%h valid=%0b expected req=1 addr=%h valid=0",
               tag, imem_req, imem_addr, instr_valid, exp_addr);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== word || instr_pc !== exp_addr || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_hold valid=%0b instr=%h pc=%h req=%0b expected valid=1 instr=%h pc=%h req=0",
               tag, instr_valid, instr, instr_pc, imem_req, word, exp_addr);
    end
  endtask

  // Called at a negedge in HOLD; retires with the given controls.
  task automatic do_retire(input logic b, input logic nb, input logic j, input logic jl,
                           input logic r, input logic z, input logic [31:0] tgt);
    branch = b; nebranch = nb; jmp = j; jal = jl; jr = r; alu_zero = z; jr_target = tgt;
    instr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_ready = 1'b0;
    branch = 0; nebranch = 0; jmp = 0; jal = 0; jr = 0; alu_zero = 0; jr_target = 32'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0 || fault_code !== 2'b00 ||
        instr !== 32'h0 || instr_pc !== 32'h0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset req=%0b valid=%0b fault=%0b code=%b instr=%h ipc=%h addr=%h expected all zero",
               imem_req, instr_valid, fault, fault_code, instr, instr_pc, imem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 4; i++) begin
      do_fetch(32'h0000_0020, 32'(i * 4), "seq");
      do_retire(0, 0, 0, 0, 0, 0, 32'h0);
    end
  endtask

  task automatic test_branch;
    do_fetch(32'h1000_FFFF, 32'h10, "beq_t");
    do_retire(1, 0, 0, 0, 0, 1, 32'h0);       // taken: 0x14 - 4
    do_fetch(32'h1000_FFFF, 32'h10, "beq_nt");
    do_retire(1, 0, 0, 0, 0, 0, 32'h0);       // not taken
    do_fetch(32'h0000_0020, 32'h14, "to10");
    do_retire(0, 0, 0, 0, 1, 0, 32'h10);
    do_fetch(32'h1400_0003, 32'h10, "bne");
    do_retire(0, 1, 0, 0, 0, 0, 32'h0);       // 0x14 + 0xC
    do_fetch(32'h1000_0001, 32'h20, "both");
    do_retire(1, 1, 0, 0, 0, 1, 32'h0);       // both set: taken, 0x24 + 4
  endtask

  task automatic test_jump;
    do_fetch(32'h0000_0020, 32'h28, "to9");
    do_retire(0, 0, 0, 0, 1, 0, 32'h9000_0000);
    do_fetch(32'h0C00_0040, 32'h9000_0000, "jal");
    checks++;
    if (link_addr !== 32'h9000_0004) begin
      errors++;
      $display("FAIL jal_link got=%h expected=%h", link_addr, 32'h9000_0004);
    end
    do_retire(0, 0, 1, 1, 0, 0, 32'h0);
    do_fetch(32'h0800_0040, 32'h9000_0100, "j");
    do_retire(1, 0, 1, 0, 1, 1, 32'h0000_0050); // jr beats jmp and branch
    do_fetch(32'h0000_0020, 32'h50, "jr_prio");
    do_retire(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC);
  endtask

  task automatic test_wrap;
    do_fetch(32'h0000_0020, 32'hFFFF_FFFC, "wrap");
    checks++;
    if (link_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_link got=%h expected=%h", link_addr, 32'h0);
    end
    do_retire(0, 0, 0, 0, 0, 0, 32'h0);
    do_fetch(32'h0000_0020, 32'h0, "wrapped");
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL hold_reset valid=%0b req=%0b instr=%h expected 0 0 0", instr_valid, imem_req, instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_jr;
    do_fetch(32'h0000_0020, 32'h0, "jr_a");
    do_retire(0, 0, 0, 0, 1, 0, 32'h44);
    do_fetch(32'h03E0_0008, 32'h44, "jr_b");
    instr_ready = 1'b0;
    do_retire(0, 0, 0, 0, 1, 0, 32'h46);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fault !== 1'b1 || fault_code !== 2'b10 || imem_req !== 1'b0 ||
          instr_valid !== 1'b0 || imem_addr !== 32'h44) begin
        errors++;
        $display("FAIL jr_misalign fault=%0b code=%b req=%0b valid=%0b addr=%h expected 1 10 0 0 00000044",
                 fault, fault_code, imem_req, instr_valid, imem_addr);
      end
      instr_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_ready = 1'b0;
    end
  endtask

  task automatic test_timeout;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (fault !== 1'b0 || fault_code !== 2'b00) begin
      errors++;
      $display("FAIL fault_clear fault=%0b code=%b expected 0 00", fault, fault_code);
    end
    rst_n = 1'b1;
    imem_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (fault !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early fault=%0b req=%0b expected 0 1", fault, imem_req);
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b01 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout fault=%0b code=%b req=%0b expected 1 01 0", fault, fault_code, imem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0 || fault_code !== 2'b00 || imem_addr !== 32'h0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_reset fault=%0b code=%b addr=%h req=%0b expected 0 00 00000000 0",
               fault, fault_code, imem_addr, imem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL restart req=%0b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    branch = 0; nebranch = 0; jmp = 0; jal = 0; jr = 0; alu_zero = 0; jr_target = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_jr();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
